aer_spike_packetizer: RTL and testbench
=======================================

# aer_spike_packetizer

Sits directly downstream of the neuron data path and converts its one-cycle output spike pulse into an address-event (AER) packet for the NoC router. Each spike is tagged with the neuron index and the node's mesh coordinates, then buffered in a small synchronous FIFO. The FIFO drains to the router over a valid/ready handshake. An end-of-timestep drain FSM tells the controller when every spike of the current step has left the node.

## Interface
- NURN_CNT_BIT_WIDTH, 8, width of neuron index
- AER_BIT_WIDTH, 32, packet width
- COORD_BIT_WIDTH, 4, width of each mesh coordinate
- TS_BIT_WIDTH, 8, timestep field width
- X_ID, 0, node X coordinate
- Y_ID, 0, node Y coordinate
- FIFO_DEPTH, 8, packet buffer entries (power of two, ≥2)
- FIFO_ADDR_WIDTH, 3, log2(FIFO_DEPTH)

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  reset: synchronous, active-high
- outSpike_i  in  1  one-cycle spike pulse from neuron data path
- nurnIdx_i  in  NURN_CNT_BIT_WIDTH  index of spiking neuron, valid with outSpike_i
- stepDone_i  in  1  controller pulse: recall phase of the current timestep finished
- packet_o  out  AER_BIT_WIDTH  head-of-FIFO packet to router
- packetValid_o  out  1  packet_o valid
- packetReady_i  in  1  router accepts packet_o
- stepFlushed_o  out  1  one-cycle pulse: FIFO drained after stepDone_i
- fifoFull_o  out  1  FIFO holds FIFO_DEPTH entries
- overflow_o  out  1  sticky: a spike was dropped

## Operation
- Packet layout, MSB first:
  - X_ID in [AER-1 -: COORD]
  - Y_ID in the next COORD bits
  - timestamp in the next TS_BIT_WIDTH bits
  - nurnIdx_i zero-extended in the remaining LSBs
- Elaboration error if AER_BIT_WIDTH < 2*COORD_BIT_WIDTH + TS_BIT_WIDTH + NURN_CNT_BIT_WIDTH.
- Push: outSpike_i=1.
- Pop: packetValid_o & packetReady_i.
- packetValid_o = FIFO not empty; packet_o = head entry, held stable while valid and not popped.
- Full with simultaneous push and pop: both accepted, count unchanged.
- Full with push and no pop: spike dropped, overflow_o set; it stays set until rst_i.
- Empty: pop cannot occur. There is no bypass; a push into an empty FIFO becomes visible the next cycle.
- Drain FSM, states RUN and DRAIN:
  - RUN → DRAIN on the edge where stepDone_i=1.
  - DRAIN → RUN on the edge where count==0 and no push occurs that cycle. On that edge stepFlushed_o is registered high for one cycle and the timestep counter increments, wrapping modulo 2^TS_BIT_WIDTH.
  - Spikes arriving in DRAIN are accepted and carry the current (old) timestamp.
  - stepDone_i in DRAIN is ignored.
- Reset values:
  - all outputs 0, packet_o 0
  - FIFO pointers and count 0
  - timestep counter 0
  - state RUN
- Reset mid-operation discards all buffered packets. packetValid_o is low in the cycle after rst_i is sampled.

## Timing
- Spike latency: push sampled at edge n; packetValid_o high from cycle n+1 if the FIFO was empty.
- Throughput: one push and one pop per cycle.
- Flush latency with an empty FIFO: stepDone_i at cycle 0 → DRAIN from cycle 1 → stepFlushed_o high in cycle 2.
- With k entries buffered and packetReady_i held high: stepFlushed_o rises 1 cycle after the last pop edge.
- All outputs are registered except packet_o, which is a combinational read of the register-file head, and packetValid_o, which is decoded from the registered count.

## Configuration
- AER_TIMESTAMP_EN:
  - Defined: the timestamp field carries the TS_BIT_WIDTH-bit timestep counter.
  - Undefined: the timestamp field is driven 0 and the counter is not instantiated.
  - The drain FSM and stepFlushed_o behave identically in both cases.

## Structure
- Package aer_pkg holds:
  - packet field offset/width localparams, derived from the parameters
  - drain FSM state encoding (RUN=1'b0, DRAIN=1'b1)
- Sub-module aer_sync_fifo:
  - generic FIFO, width AER_BIT_WIDTH, depth FIFO_DEPTH
  - push, pop, head data, count, full, empty
  - synchronous active-high reset
- Top level contains packet assembly, overflow flag, timestep counter and drain FSM.

## Test plan
- Single spike: X_ID=3, Y_ID=5, nurnIdx_i=8'h2A, ready=1, macro off → packet_o=32'h3500002A valid exactly one cycle, starting the cycle after the pulse.
- Back-pressure: 8 spikes (idx 0..7) with ready=0 → fifoFull_o=1, overflow_o=0. Then ready=1 → idx 0..7 emitted in order on 8 consecutive cycles.
- Overflow: FIFO full, ready=0, spike idx 9 → overflow_o=1, idx 9 never emitted. Full with push and pop in the same cycle → no overflow, new entry emitted last.
- Drain: 3 buffered, stepDone_i pulse, ready=1 → 3 pops, stepFlushed_o one-cycle pulse the cycle after the last pop. Empty FIFO → stepFlushed_o 2 cycles after stepDone_i.
- Timestamp (macro on): 256 stepDone/flush cycles, then a spike → timestamp field 0 (wrap). After 1 flush → field 1.
- Mid-operation reset: 4 buffered, FSM in DRAIN, rst_i for 1 cycle → packetValid_o=0, overflow_o=0, state RUN, no stepFlushed_o pulse.

Source files
------------

// File: rtl/aer_pkg.sv
// Shared definitions for the AER spike packetizer: drain FSM encoding and
// packet field placement helpers (fields are packed MSB-first from the top).
package aer_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;

    localparam int AER_BIT_WIDTH_DEF   = 32;
    localparam int COORD_BIT_WIDTH_DEF = 4;
    localparam int TS_BIT_WIDTH_DEF    = 8;
    localparam int NURN_BIT_WIDTH_DEF  = 8;

    function automatic int x_msb(input int aer_w);
        return aer_w - 1;
    endfunction

    function automatic int y_msb(input int aer_w, input int coord_w);
        return aer_w - 1 - coord_w;
    endfunction

    function automatic int ts_msb(input int aer_w, input int coord_w);
        return aer_w - 1 - 2 * coord_w;
    endfunction

    function automatic int min_aer_w(input int coord_w, input int ts_w, input int nurn_w);
        return 2 * coord_w + ts_w + nurn_w;
    endfunction

endpackage

// File: rtl/aer_sync_fifo.sv
// Generic synchronous FIFO; a push into a full FIFO is accepted only when a
// pop frees a slot in the same cycle. Head output reads 0 while empty.
module aer_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [AW:0]      count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, full_d;
    logic             push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_q | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d = (count_d == (AW+1)'(DEPTH));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = full_q;

endmodule

// File: rtl/aer_spike_packetizer.sv
// Spike-to-AER packetizer: tags spikes with node coordinates and timestep,
// buffers them for the router and signals end-of-step drain. Timestamp field
// is live only when AER_TIMESTAMP_EN is defined.
module aer_spike_packetizer
    import aer_pkg::*;
#(
    parameter int NURN_CNT_BIT_WIDTH = 8,
    parameter int AER_BIT_WIDTH      = 32,
    parameter int COORD_BIT_WIDTH    = 4,
    parameter int TS_BIT_WIDTH       = 8,
    parameter int X_ID               = 0,
    parameter int Y_ID               = 0,
    parameter int FIFO_DEPTH         = 8,
    parameter int FIFO_ADDR_WIDTH    = 3
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          outSpike_i,
    input  logic [NURN_CNT_BIT_WIDTH-1:0] nurnIdx_i,
    input  logic                          stepDone_i,
    output logic [AER_BIT_WIDTH-1:0]      packet_o,
    output logic                          packetValid_o,
    input  logic                          packetReady_i,
    output logic                          stepFlushed_o,
    output logic                          fifoFull_o,
    output logic                          overflow_o
);

    localparam int X_MSB  = x_msb(AER_BIT_WIDTH);
    localparam int Y_MSB  = y_msb(AER_BIT_WIDTH, COORD_BIT_WIDTH);
    localparam int TS_MSB = ts_msb(AER_BIT_WIDTH, COORD_BIT_WIDTH);

    if (AER_BIT_WIDTH < min_aer_w(COORD_BIT_WIDTH, TS_BIT_WIDTH, NURN_CNT_BIT_WIDTH)) begin : g_bad_width
        $error("AER_BIT_WIDTH too small for coordinate, timestamp and neuron fields");
    end

    logic [AER_BIT_WIDTH-1:0]   pkt;
    logic [TS_BIT_WIDTH-1:0]    ts_field;
    logic [FIFO_ADDR_WIDTH:0]   fifo_count;
    logic                       fifo_full, fifo_empty, pop;
    drain_state_e               state_q, state_d;
    logic                       flushed_q, flushed_d;
    logic                       overflow_q, overflow_d;

    always_comb begin
        pkt                          = '0;
        pkt[NURN_CNT_BIT_WIDTH-1:0]  = nurnIdx_i;
        pkt[TS_MSB -: TS_BIT_WIDTH]  = ts_field;
        pkt[Y_MSB -: COORD_BIT_WIDTH] = COORD_BIT_WIDTH'(Y_ID);
        pkt[X_MSB -: COORD_BIT_WIDTH] = COORD_BIT_WIDTH'(X_ID);
    end

    assign pop = packetValid_o & packetReady_i;

    aer_sync_fifo #(
        .WIDTH (AER_BIT_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (outSpike_i),
        .data_i  (pkt),
        .pop_i   (pop),
        .head_o  (packet_o),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign packetValid_o = ~fifo_empty;
    assign fifoFull_o    = fifo_full;

    // A push into a full FIFO is only lost when no pop frees a slot that cycle.
    assign overflow_d = overflow_q | (outSpike_i & fifo_full & ~pop);

    always_comb begin
        state_d   = state_q;
        flushed_d = 1'b0;
        case (state_q)
            RUN:   if (stepDone_i) state_d = DRAIN;
            DRAIN: if ((fifo_count == '0) && !outSpike_i) begin
                state_d   = RUN;
                flushed_d = 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            flushed_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            flushed_q  <= flushed_d;
            overflow_q <= overflow_d;
        end
    end

    assign stepFlushed_o = flushed_q;
    assign overflow_o    = overflow_q;

`ifdef AER_TIMESTAMP_EN
    logic [TS_BIT_WIDTH-1:0] ts_q, ts_d;

    assign ts_d = flushed_d ? ts_q + 1'b1 : ts_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) ts_q <= '0;
        else       ts_q <= ts_d;
    end

    assign ts_field = ts_q;
`else
    assign ts_field = '0;
`endif

endmodule

// File: tb/tb_aer_spike_packetizer.sv
// Directed bench for aer_spike_packetizer (node X=3, Y=5); expected packets
// come from a bench-side timestep model that follows the build macro.
module tb_aer_spike_packetizer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        outSpike_i;
    logic [7:0]  nurnIdx_i;
    logic        stepDone_i;
    logic [31:0] packet_o;
    logic        packetValid_o;
    logic        packetReady_i;
    logic        stepFlushed_o;
    logic        fifoFull_o;
    logic        overflow_o;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  ts_m = 8'd0;

    always #5 clk_i = ~clk_i;

    aer_spike_packetizer #(
        .NURN_CNT_BIT_WIDTH (8),
        .AER_BIT_WIDTH      (32),
        .COORD_BIT_WIDTH    (4),
        .TS_BIT_WIDTH       (8),
        .X_ID               (3),
        .Y_ID               (5),
        .FIFO_DEPTH         (8),
        .FIFO_ADDR_WIDTH    (3)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .outSpike_i    (outSpike_i),
        .nurnIdx_i     (nurnIdx_i),
        .stepDone_i    (stepDone_i),
        .packet_o      (packet_o),
        .packetValid_o (packetValid_o),
        .packetReady_i (packetReady_i),
        .stepFlushed_o (stepFlushed_o),
        .fifoFull_o    (fifoFull_o),
        .overflow_o    (overflow_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_pkt(input logic [7:0] idx);
        logic [7:0] t;
`ifdef AER_TIMESTAMP_EN
        t = ts_m;
`else
        t = 8'd0;
`endif
        return {4'd3, 4'd5, t, 8'h00, idx};
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [7:0] idx);
        outSpike_i = 1'b1;
        nurnIdx_i  = idx;
        step();
        outSpike_i = 1'b0;
    endtask

    // Flush with an empty FIFO: pulse lands two cycles after stepDone_i.
    task automatic flush_empty(input logic check_all);
        stepDone_i = 1'b1;
        step();
        stepDone_i = 1'b0;
        if (check_all) chk("flush_early", {31'd0, stepFlushed_o}, 32'd0);
        step();
        ts_m++;
        chk("flush_pulse", {31'd0, stepFlushed_o}, 32'd1);
        step();
        if (check_all) chk("flush_len", {31'd0, stepFlushed_o}, 32'd0);
    endtask

    task automatic spike_ts(input string tag, input logic [7:0] idx);
        packetReady_i = 1'b1;
        push(idx);
        chk({tag, "_vld"}, {31'd0, packetValid_o}, 32'd1);
        chk({tag, "_pkt"}, packet_o, exp_pkt(idx));
        step();
        chk({tag, "_gone"}, {31'd0, packetValid_o}, 32'd0);
    endtask

    initial begin
        rst_i = 1'b1; outSpike_i = 1'b0; nurnIdx_i = '0;
        stepDone_i = 1'b0; packetReady_i = 1'b0;
        step(); step();
        chk("rst_pkt", packet_o, 32'd0);
        chk("rst_vld", {31'd0, packetValid_o}, 32'd0);
        chk("rst_full", {31'd0, fifoFull_o}, 32'd0);
        chk("rst_ovf", {31'd0, overflow_o}, 32'd0);
        chk("rst_flush", {31'd0, stepFlushed_o}, 32'd0);
        rst_i = 1'b0;
        step();

        // Single spike: visible next cycle, gone after one accepted cycle.
        packetReady_i = 1'b1;
        chk("single_pre", {31'd0, packetValid_o}, 32'd0);
        push(8'h2A);
        chk("single_vld", {31'd0, packetValid_o}, 32'd1);
        chk("single_pkt", packet_o, 32'h3500002A);
        step();
        chk("single_once", {31'd0, packetValid_o}, 32'd0);

        // Back-pressure fill and in-order drain.
        packetReady_i = 1'b0;
        for (int i = 0; i < 8; i++) push(8'(i));
        chk("bp_full", {31'd0, fifoFull_o}, 32'd1);
        chk("bp_ovf", {31'd0, overflow_o}, 32'd0);
        chk("bp_hold", packet_o, exp_pkt(8'd0));
        packetReady_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("bp_vld", {31'd0, packetValid_o}, 32'd1);
            chk("bp_order", packet_o, exp_pkt(8'(i)));
            step();
        end
        chk("bp_empty", {31'd0, packetValid_o}, 32'd0);
        chk("bp_notfull", {31'd0, fifoFull_o}, 32'd0);

        // Full: push+pop is accepted, push alone is dropped.
        packetReady_i = 1'b0;
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        packetReady_i = 1'b1;
        push(8'h55);
        chk("pp_full", {31'd0, fifoFull_o}, 32'd1);
        chk("pp_noovf", {31'd0, overflow_o}, 32'd0);
        packetReady_i = 1'b0;
        push(8'h09);
        chk("ovf_set", {31'd0, overflow_o}, 32'd1);
        packetReady_i = 1'b1;
        for (int i = 1; i < 8; i++) begin
            chk("ovf_order", packet_o, exp_pkt(8'h10 + 8'(i)));
            step();
        end
        chk("ovf_last", packet_o, exp_pkt(8'h55));
        step();
        chk("ovf_empty", {31'd0, packetValid_o}, 32'd0);
        chk("ovf_sticky", {31'd0, overflow_o}, 32'd1);

        // Reset while draining discards contents and returns to RUN.
        packetReady_i = 1'b0;
        for (int i = 0; i < 4; i++) push(8'h20 + 8'(i));
        stepDone_i = 1'b1;
        step();
        stepDone_i = 1'b0;
        step();
        chk("mr_pre_vld", {31'd0, packetValid_o}, 32'd1);
        rst_i = 1'b1;
        step();
        chk("mr_vld", {31'd0, packetValid_o}, 32'd0);
        chk("mr_ovf", {31'd0, overflow_o}, 32'd0);
        chk("mr_pkt", packet_o, 32'd0);
        rst_i = 1'b0;
        ts_m = 8'd0;
        packetReady_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mr_noflush", {31'd0, stepFlushed_o}, 32'd0);
        end

        // Drain three buffered entries; pulse one cycle after last pop.
        packetReady_i = 1'b0;
        for (int i = 0; i < 3; i++) push(8'h30 + 8'(i));
        chk("dr_head", packet_o, exp_pkt(8'h30));
        packetReady_i = 1'b1;
        stepDone_i = 1'b1;
        step();
        stepDone_i = 1'b0;
        chk("dr_pop1", packet_o, exp_pkt(8'h31));
        chk("dr_nf1", {31'd0, stepFlushed_o}, 32'd0);
        step();
        chk("dr_pop2", packet_o, exp_pkt(8'h32));
        step();
        chk("dr_empty", {31'd0, packetValid_o}, 32'd0);
        chk("dr_nf3", {31'd0, stepFlushed_o}, 32'd0);
        step();
        ts_m++;
        chk("dr_flush", {31'd0, stepFlushed_o}, 32'd1);
        step();
        chk("dr_once", {31'd0, stepFlushed_o}, 32'd0);

        flush_empty(1'b1);
        spike_ts("ts2", 8'h41);

        // Spike in DRAIN keeps the old timestamp and postpones the flush.
        stepDone_i = 1'b1;
        step();
        stepDone_i = 1'b0;
        push(8'h77);
        chk("dsp_nf", {31'd0, stepFlushed_o}, 32'd0);
        chk("dsp_pkt", packet_o, exp_pkt(8'h77));
        step();
        chk("dsp_nf2", {31'd0, stepFlushed_o}, 32'd0);
        step();
        ts_m++;
        chk("dsp_flush", {31'd0, stepFlushed_o}, 32'd1);

        for (int i = 0; i < 300 && ts_m != 8'd0; i++) flush_empty(1'b0);
        chk("ts_wrapmodel", {24'd0, ts_m}, 32'd0);
        spike_ts("ts_wrap", 8'h5A);
        flush_empty(1'b1);
        spike_ts("ts_one", 8'h5B);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
